// File: rtl/control_sequencer.sv
// Hardwired control unit for the datapath: fetch in T0-T2, then decode IR and
// run the execute states T3-T6. All strobes are Moore decodes of r_state.
module control_sequencer #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        Read,
    output logic        MDRin,
    output logic        MARin,
    output logic        IRin,
    output logic        PCin,
    output logic        IncPC,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  opcode,
    output logic        run,
    output logic        illegal,
    output logic        mem_err
);

    typedef enum logic [3:0] {
        ST_RESET,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    localparam logic [4:0] OP_ALU_LO = 5'b00011;
    localparam logic [4:0] OP_ALU_HI = 5'b01011;
    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_DIV    = 5'b10000;
    localparam logic [4:0] OP_NEG    = 5'b10001;
    localparam logic [4:0] OP_NOT    = 5'b10010;
    localparam logic [4:0] OP_NOP    = 5'b11010;
    localparam logic [4:0] OP_HALT   = 5'b11011;

    // Last waiting cycle index; T1 waits at most MEM_WAIT_MAX cycles.
    localparam logic [9:0] WAIT_LAST = 10'(MEM_WAIT_MAX - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [9:0]  r_wait_cnt;
    logic        r_mem_err;

    logic [4:0]  w_op;
    logic [15:0] w_ra_hot;
    logic [15:0] w_rb_hot;
    logic [15:0] w_rc_hot;
    logic        w_is_alu;
    logic        w_is_muldiv;
    logic        w_is_unary;
    logic        w_is_nop;
    logic        w_is_halt;
    logic        w_timeout;
    logic        w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_ra_hot    = 16'h0001 << ir[26:23];
    assign w_rb_hot    = 16'h0001 << ir[22:19];
    assign w_rc_hot    = 16'h0001 << ir[18:15];
    assign w_is_alu    = (w_op >= OP_ALU_LO) && (w_op <= OP_ALU_HI);
    assign w_is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
    assign w_is_unary  = (w_op == OP_NEG) || (w_op == OP_NOT);
    assign w_is_nop    = (w_op == OP_NOP);
    assign w_is_halt   = (w_op == OP_HALT);
    assign w_timeout   = (r_state == ST_T1) && !mem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_unused_ir = ^ir[14:0];

    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (clear) begin
            r_state    <= ST_RESET;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_T1) && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 10'd1;
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output and the next state get a default first, so no path infers a latch.
        w_next_state = r_state;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MARin    = 1'b0;
        IRin     = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        opcode   = '0;
        illegal  = 1'b0;
        run      = (r_state != ST_RESET) && (r_state != ST_HALT);
        mem_err  = r_mem_err;

        case (r_state)
            ST_RESET: w_next_state = ST_T0;
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
                w_next_state = ST_T1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                if (mem_ready) begin
                    w_next_state = ST_T2;
                end else if (w_timeout) begin
                    w_next_state = ST_HALT;
                end
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                w_next_state = ST_T3;
            end
            ST_T3: begin
                w_next_state = ST_T0;
                if (w_is_alu) begin
                    Rout = w_rb_hot;
                    Yin  = 1'b1;
                    w_next_state = ST_T4;
                end else if (w_is_muldiv) begin
                    Rout = w_ra_hot;
                    Yin  = 1'b1;
                    w_next_state = ST_T4;
                end else if (w_is_unary) begin
                    Rout   = w_rb_hot;
                    opcode = w_op;
                    Zin    = 1'b1;
                    w_next_state = ST_T4;
                end else if (w_is_halt) begin
                    w_next_state = ST_HALT;
                end else if (!w_is_nop) begin
                    illegal = 1'b1;
                end
            end
            ST_T4: begin
                w_next_state = ST_T0;
                if (w_is_alu) begin
                    Rout   = w_rc_hot;
                    opcode = w_op;
                    Zin    = 1'b1;
                    w_next_state = ST_T5;
                end else if (w_is_muldiv) begin
                    Rout   = w_rb_hot;
                    opcode = w_op;
                    Zin    = 1'b1;
                    w_next_state = ST_T5;
                end else if (w_is_unary) begin
                    Zlowout = 1'b1;
                    Rin     = w_ra_hot;
                end
            end
            ST_T5: begin
                w_next_state = ST_T0;
                if (w_is_alu) begin
                    Zlowout = 1'b1;
                    Rin     = w_ra_hot;
                end else if (w_is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                    w_next_state = ST_T6;
                end
            end
            ST_T6: begin
                w_next_state = ST_T0;
                if (w_is_muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small behavioural datapath executes the strobes,
// directed instruction sequences are checked cycle by cycle against hand-derived values.
module tb_control_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [13:0] K_READ   = 14'h2000;
    localparam logic [13:0] K_MDRIN  = 14'h1000;
    localparam logic [13:0] K_MARIN  = 14'h0800;
    localparam logic [13:0] K_IRIN   = 14'h0400;
    localparam logic [13:0] K_PCIN   = 14'h0200;
    localparam logic [13:0] K_INCPC  = 14'h0100;
    localparam logic [13:0] K_PCOUT  = 14'h0080;
    localparam logic [13:0] K_MDROUT = 14'h0040;
    localparam logic [13:0] K_ZHI    = 14'h0020;
    localparam logic [13:0] K_ZLO    = 14'h0010;
    localparam logic [13:0] K_YIN    = 14'h0008;
    localparam logic [13:0] K_ZIN    = 14'h0004;
    localparam logic [13:0] K_HIIN   = 14'h0002;
    localparam logic [13:0] K_LOIN   = 14'h0001;
    localparam logic [13:0] C_T0 = K_PCOUT | K_MARIN | K_INCPC | K_ZIN;
    localparam logic [13:0] C_T1 = K_ZLO | K_PCIN | K_READ | K_MDRIN;
    localparam logic [13:0] C_T2 = K_MDROUT | K_IRIN;

    logic        clear, clear_to, mem_ready;
    logic [31:0] ir_q;

    logic Read, MDRin, MARin, IRin, PCin, IncPC, PCout, MDRout;
    logic Zhighout, Zlowout, Yin, Zin, HIin, LOin, run, illegal, mem_err;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;
    logic [13:0] ctrl;

    logic to_Read, to_MDRin, to_MARin, to_IRin, to_PCin, to_IncPC, to_PCout, to_MDRout;
    logic to_Zhighout, to_Zlowout, to_Yin, to_Zin, to_HIin, to_LOin, to_run, to_illegal, to_mem_err;
    logic [15:0] to_Rin, to_Rout;
    logic [4:0]  to_opcode;
    logic [13:0] to_ctrl;

    assign ctrl = {Read, MDRin, MARin, IRin, PCin, IncPC, PCout, MDRout,
                   Zhighout, Zlowout, Yin, Zin, HIin, LOin};
    assign to_ctrl = {to_Read, to_MDRin, to_MARin, to_IRin, to_PCin, to_IncPC, to_PCout, to_MDRout,
                      to_Zhighout, to_Zlowout, to_Yin, to_Zin, to_HIin, to_LOin};

    control_sequencer #(.MEM_WAIT_MAX(255)) u_dut (
        .Clock(clk), .clear(clear), .ir(ir_q), .mem_ready(mem_ready),
        .Read(Read), .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .PCin(PCin), .IncPC(IncPC),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout),
        .opcode(opcode), .run(run), .illegal(illegal), .mem_err(mem_err)
    );

    // Second instance with a short wait limit and memory that never answers.
    control_sequencer #(.MEM_WAIT_MAX(4)) u_to (
        .Clock(clk), .clear(clear_to), .ir(32'h0), .mem_ready(1'b0),
        .Read(to_Read), .MDRin(to_MDRin), .MARin(to_MARin), .IRin(to_IRin), .PCin(to_PCin),
        .IncPC(to_IncPC), .PCout(to_PCout), .MDRout(to_MDRout), .Zhighout(to_Zhighout),
        .Zlowout(to_Zlowout), .Yin(to_Yin), .Zin(to_Zin), .HIin(to_HIin), .LOin(to_LOin),
        .Rin(to_Rin), .Rout(to_Rout), .opcode(to_opcode), .run(to_run),
        .illegal(to_illegal), .mem_err(to_mem_err)
    );

    // Behavioural datapath driven by the main instance's strobes.
    logic [31:0] rf [16];
    logic [31:0] mem [16];
    logic [31:0] pc, mar, mdr, y, hi, lo, bus;
    logic [63:0] z;
    logic        dp_we;
    logic [4:0]  dp_sel;
    logic [31:0] dp_val;

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            5'b00011: alu = {32'h0, a + b};
            5'b00100: alu = {32'h0, a - b};
            5'b00101: alu = {32'h0, a & b};
            5'b00110: alu = {32'h0, a | b};
            5'b01111: alu = sa * sb;
            5'b10000: alu = (b == 32'h0) ? 64'h0 : {32'(sa % sb), 32'(sa / sb)};
            5'b10001: alu = {32'h0, 32'h0 - b};
            5'b10010: alu = {32'h0, ~b};
            default:  alu = 64'h0;
        endcase
    endfunction

    always_comb begin
        bus = 32'h0;
        if (PCout) bus = pc;
        else if (MDRout) bus = mdr;
        else if (Zhighout) bus = z[63:32];
        else if (Zlowout) bus = z[31:0];
        else begin
            for (int i = 0; i < 16; i++) begin
                if (Rout[i]) bus = rf[i];
            end
        end
    end

    always @(posedge clk) begin
        if (dp_we) begin
            if (dp_sel == 5'd16) pc <= dp_val;
            else if (dp_sel == 5'd17) ir_q <= dp_val;
            else rf[dp_sel[3:0]] <= dp_val;
        end
        if (MARin) mar <= bus;
        if (PCin) pc <= bus;
        if (Read && MDRin && mem_ready) mdr <= mem[mar[3:0]];
        if (IRin) ir_q <= bus;
        if (Yin) y <= bus;
        if (Zin) z <= IncPC ? {32'h0, bus + 32'd1} : alu(opcode, y, bus);
        if (HIin) hi <= bus;
        if (LOin) lo <= bus;
        for (int i = 0; i < 16; i++) begin
            if (Rin[i]) rf[i] <= bus;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic mon_en = 1'b0;
    logic watch_lohi = 1'b0;
    logic lohi_seen = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("bus_main", 64'((int'($countones(Rout)) + int'(PCout) + int'(MDRout)
                                 + int'(Zhighout) + int'(Zlowout)) > 1), 64'(0));
            check("bus_to", 64'((int'($countones(to_Rout)) + int'(to_PCout) + int'(to_MDRout)
                               + int'(to_Zhighout) + int'(to_Zlowout)) > 1), 64'(0));
            if (watch_lohi && (LOin || HIin)) lohi_seen <= 1'b1;
        end
    end

    task automatic check_st(input string tag, input logic [13:0] c, input logic [15:0] ri,
                            input logic [15:0] ro, input logic [4:0] op);
        check({tag, "_ctrl"}, 64'(ctrl), 64'(c));
        check({tag, "_rin"}, 64'(Rin), 64'(ri));
        check({tag, "_rout"}, 64'(Rout), 64'(ro));
        check({tag, "_op"}, 64'(opcode), 64'(op));
        check({tag, "_run"}, 64'(run), 64'(1));
    endtask

    task automatic expect_st(input string tag, input logic [13:0] c, input logic [15:0] ri,
                             input logic [15:0] ro, input logic [4:0] op);
        check_st(tag, c, ri, ro, op);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctrl"}, 64'(ctrl), 64'(0));
        check({tag, "_rin"}, 64'(Rin), 64'(0));
        check({tag, "_rout"}, 64'(Rout), 64'(0));
        check({tag, "_op"}, 64'(opcode), 64'(0));
        check({tag, "_run"}, 64'(run), 64'(0));
        check({tag, "_ill"}, 64'(illegal), 64'(0));
    endtask

    task automatic fetch(input string tag);
        expect_st({tag, "_t0"}, C_T0, 16'h0, 16'h0, 5'h0);
        expect_st({tag, "_t1"}, C_T1, 16'h0, 16'h0, 5'h0);
        expect_st({tag, "_t2"}, C_T2, 16'h0, 16'h0, 5'h0);
    endtask

    task automatic preset(input logic [4:0] sel, input logic [31:0] val);
        dp_we  = 1'b1;
        dp_sel = sel;
        dp_val = val;
        @(negedge clk);
        dp_we  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear = 1'b1;
        clear_to = 1'b1;
        mem_ready = 1'b1;
        dp_we = 1'b0;
        dp_sel = 5'd0;
        dp_val = 32'h0;
        for (int i = 0; i < 16; i++) mem[i] = 32'hD000_0000;
        mem[0] = 32'h7918_0000;  // mul R2,R3
        mem[1] = 32'h1899_8000;  // add R1,R3,R3
        mem[2] = 32'hD000_0000;  // nop
        mem[3] = 32'hF800_0000;  // op 11111
        mem[4] = 32'hD800_0000;  // halt
        mem[5] = 32'h7918_0000;  // mul, cut short by clear
        mem[6] = 32'hD800_0000;  // halt

        @(negedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        check_idle("rst");
        check("rst_memerr", 64'(mem_err), 64'(0));
        preset(5'd16, 32'h0);
        preset(5'd17, 32'h0);
        preset(5'd1, 32'h0);
        preset(5'd2, 32'hFFFF_FFFC);
        preset(5'd3, 32'h5);
        clear = 1'b0;
        @(negedge clk);

        fetch("mul");
        expect_st("mul_t3", K_YIN, 16'h0, 16'h0004, 5'h0);
        expect_st("mul_t4", K_ZIN, 16'h0, 16'h0008, 5'b01111);
        expect_st("mul_t5", K_ZLO | K_LOIN, 16'h0, 16'h0, 5'h0);
        expect_st("mul_t6", K_ZHI | K_HIIN, 16'h0, 16'h0, 5'h0);
        check("mul_lo", 64'(lo), 64'(32'hFFFF_FFEC));
        check("mul_hi", 64'(hi), 64'(32'hFFFF_FFFF));

        fetch("add");
        expect_st("add_t3", K_YIN, 16'h0, 16'h0008, 5'h0);
        expect_st("add_t4", K_ZIN, 16'h0, 16'h0008, 5'b00011);
        expect_st("add_t5", K_ZLO, 16'h0002, 16'h0, 5'h0);
        check("add_r1", 64'(rf[1]), 64'(10));

        mem_ready = 1'b0;
        expect_st("wait_t0", C_T0, 16'h0, 16'h0, 5'h0);
        expect_st("wait_t1a", C_T1, 16'h0, 16'h0, 5'h0);
        expect_st("wait_t1b", C_T1, 16'h0, 16'h0, 5'h0);
        expect_st("wait_t1c", C_T1, 16'h0, 16'h0, 5'h0);
        mem_ready = 1'b1;
        expect_st("wait_t1d", C_T1, 16'h0, 16'h0, 5'h0);
        check("wait_memerr", 64'(mem_err), 64'(0));
        expect_st("wait_t2", C_T2, 16'h0, 16'h0, 5'h0);
        check("nop_ir", 64'(ir_q), 64'(32'hD000_0000));
        check("nop_ill", 64'(illegal), 64'(0));
        expect_st("nop_t3", 14'h0, 16'h0, 16'h0, 5'h0);

        fetch("ill");
        check("ill_pulse", 64'(illegal), 64'(1));
        expect_st("ill_t3", 14'h0, 16'h0, 16'h0, 5'h0);
        check("ill_drop", 64'(illegal), 64'(0));

        fetch("halt");
        check("halt_t3_ill", 64'(illegal), 64'(0));
        expect_st("halt_t3", 14'h0, 16'h0, 16'h0, 5'h0);
        for (int i = 0; i < 20; i++) begin
            check_idle("halt_hold");
            @(negedge clk);
        end

        clear = 1'b1;
        @(negedge clk);
        check_idle("rst2");
        preset(5'd16, 32'h5);
        clear = 1'b0;
        @(negedge clk);
        fetch("mc");
        expect_st("mc_t3", K_YIN, 16'h0, 16'h0004, 5'h0);
        expect_st("mc_t4", K_ZIN, 16'h0, 16'h0008, 5'b01111);
        check_st("mc_t5", K_ZLO | K_LOIN, 16'h0, 16'h0, 5'h0);
        clear = 1'b1;
        @(negedge clk);
        watch_lohi = 1'b1;
        check_idle("mc_rst");
        check("mc_rst_memerr", 64'(mem_err), 64'(0));
        clear = 1'b0;
        @(negedge clk);
        fetch("mc_next");
        expect_st("mc_next_t3", 14'h0, 16'h0, 16'h0, 5'h0);
        check_idle("mc_halt");
        check("mc_no_lohi", 64'(lohi_seen), 64'(0));

        clear_to = 1'b0;
        @(negedge clk);
        check("to_t0", 64'(to_ctrl), 64'(C_T0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("to_t1", 64'(to_ctrl), 64'(C_T1));
            check("to_t1_run", 64'(to_run), 64'(1));
            check("to_t1_err", 64'(to_mem_err), 64'(0));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("to_halt_ctrl", 64'(to_ctrl), 64'(0));
            check("to_halt_bus", 64'({to_Rin, to_Rout, to_opcode, to_illegal}), 64'(0));
            check("to_halt_run", 64'(to_run), 64'(0));
            check("to_halt_err", 64'(to_mem_err), 64'(1));
        end
        clear_to = 1'b1;
        @(negedge clk);
        check("to_clr_err", 64'(to_mem_err), 64'(0));
        check("main_memerr", 64'(mem_err), 64'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
